// File: rtl/cpl_timeout_pkg.sv
// cpl_timeout_pkg: tag state encoding, default sizes and saturating counter helper
package cpl_timeout_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_EXPIRED} tag_state_t;
  localparam int NUM_TAGS_DEF = 16;
  localparam int CNT_W_DEF = 32;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/cpl_tag_timer.sv
// cpl_tag_timer: per-tag IDLE/ACTIVE/EXPIRED state with a timer that runs only while ACTIVE
module cpl_tag_timer
  import cpl_timeout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_arm,
  input  logic             i_clr,
  input  logic             i_ack,
  input  logic [CNT_W-1:0] i_limit,
  output logic [1:0]       o_state
);
  tag_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end
  // completion beats expiry; a same-cycle request re-arms after the completion
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    case (r_state)
      ST_IDLE:    w_state_nxt = i_arm ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE:
        if (i_clr) w_state_nxt = i_arm ? ST_ACTIVE : ST_IDLE;
        else if (r_timer >= i_limit) w_state_nxt = ST_EXPIRED;
        else w_timer_nxt = r_timer + 1'b1;
      ST_EXPIRED: w_state_nxt = i_ack ? ST_IDLE : ST_EXPIRED;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end
  assign o_state = r_state;
endmodule

// File: rtl/cpl_timeout_monitor.sv
// cpl_timeout_monitor: per-tag completion timeout tracking with serialized expiry reports and error tally
module cpl_timeout_monitor
  import cpl_timeout_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEF,
  parameter int TAG_W    = 4,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_timeout_limit,
  input  logic             i_req_valid,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic             i_cpl_valid,
  input  logic [TAG_W-1:0] i_cpl_tag,
  output logic             o_timeout_valid,
  output logic [TAG_W-1:0] o_timeout_tag,
  output logic             o_err_req_dup,
  output logic             o_err_cpl_unexp,
  output logic [TAG_W:0]   o_outstanding,
  output logic [31:0]      o_err_count,
  output logic             o_idle
);
  logic [1:0]       w_state [NUM_TAGS];
  logic             w_sel_vld, w_req_ok, w_cpl_ok, w_dup, w_unexp;
  logic [TAG_W-1:0] w_sel;
  logic [TAG_W:0]   w_out_nxt;
  logic [1:0]       w_inc;
  logic             r_tv, r_dup, r_unexp, r_idle;
  logic [TAG_W-1:0] r_tt;
  logic [TAG_W:0]   r_out;
  logic [31:0]      r_err_count;
  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    cpl_tag_timer #(.CNT_W(CNT_W)) u_tmr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_arm   (i_req_valid && i_req_tag == TAG_W'(g)),
      .i_clr   (i_cpl_valid && i_cpl_tag == TAG_W'(g)),
      .i_ack   (w_sel_vld && w_sel == TAG_W'(g)),
      .i_limit (i_timeout_limit),
      .o_state (w_state[g])
    );
  end
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (w_state[i] == ST_EXPIRED) begin
        w_sel_vld = 1'b1;
        w_sel     = TAG_W'(i);
      end
  end
  // request is judged against the state left after a same-cycle completion
  assign w_cpl_ok  = i_cpl_valid && w_state[i_cpl_tag] == ST_ACTIVE;
  assign w_unexp   = i_cpl_valid && !w_cpl_ok;
  assign w_req_ok  = i_req_valid && (w_state[i_req_tag] == ST_IDLE ||
                     (w_cpl_ok && i_cpl_tag == i_req_tag));
  assign w_dup     = i_req_valid && !w_req_ok;
  assign w_out_nxt = r_out + (TAG_W+1)'(w_req_ok) - (TAG_W+1)'(w_cpl_ok) - (TAG_W+1)'(w_sel_vld);
  assign w_inc     = 2'(w_sel_vld) + 2'(w_dup) + 2'(w_unexp);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tv        <= 1'b0;
      r_tt        <= '0;
      r_dup       <= 1'b0;
      r_unexp     <= 1'b0;
      r_out       <= '0;
      r_idle      <= 1'b1;
      r_err_count <= '0;
    end else begin
      r_tv        <= w_sel_vld;
      r_tt        <= w_sel;
      r_dup       <= w_dup;
      r_unexp     <= w_unexp;
      r_out       <= w_out_nxt;
      r_idle      <= w_out_nxt == '0;
      r_err_count <= sat_add(r_err_count, w_inc);
    end
  end
  assign o_timeout_valid = r_tv;
  assign o_timeout_tag   = r_tt;
  assign o_err_req_dup   = r_dup;
  assign o_err_cpl_unexp = r_unexp;
  assign o_outstanding   = r_out;
  assign o_err_count     = r_err_count;
  assign o_idle          = r_idle;
endmodule

// File: tb/tb_cpl_timeout_monitor.sv
// tb_cpl_timeout_monitor: directed and random checks against a cycle-numbered tag model
module tb_cpl_timeout_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] timeout_limit;
  logic        req_valid, cpl_valid;
  logic [3:0]  req_tag, cpl_tag;
  logic        timeout_valid, err_req_dup, err_cpl_unexp, idle;
  logic [3:0]  timeout_tag;
  logic [4:0]  outstanding;
  logic [31:0] err_count;
  int n_cmp = 0;
  int n_fail = 0;
  int     ms [16];
  longint marm [16];
  longint ncyc = 0;
  logic        mv, md, mu;
  logic [3:0]  mt;
  logic [31:0] me;
  int          mo;

  always #5 clk = ~clk;

  cpl_timeout_monitor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_timeout_limit(timeout_limit),
    .i_req_valid(req_valid), .i_req_tag(req_tag),
    .i_cpl_valid(cpl_valid), .i_cpl_tag(cpl_tag),
    .o_timeout_valid(timeout_valid), .o_timeout_tag(timeout_tag),
    .o_err_req_dup(err_req_dup), .o_err_cpl_unexp(err_cpl_unexp),
    .o_outstanding(outstanding), .o_err_count(err_count), .o_idle(idle)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tag states: 0 idle, 1 active, 2 expired; a tag armed at edge a has timer n-1-a before edge n
  task automatic model_edge();
    int s [16];
    int sel, ps;
    longint n, tot;
    n = ncyc;
    ncyc++;
    if (!rst_n) begin
      foreach (ms[t]) ms[t] = 0;
      mv = 0; mt = 0; md = 0; mu = 0; mo = 0; me = 0;
      return;
    end
    s = ms;
    sel = -1;
    for (int t = 15; t >= 0; t--) if (s[t] == 2) sel = t;
    mv = sel >= 0;
    mt = mv ? 4'(sel) : 4'd0;
    mu = cpl_valid && s[cpl_tag] != 1;
    ps = (cpl_valid && cpl_tag == req_tag && s[req_tag] == 1) ? 0 : s[req_tag];
    md = req_valid && ps != 0;
    for (int t = 0; t < 16; t++) begin
      if (s[t] == 2 && t == sel) ms[t] = 0;
      else if (s[t] == 1) begin
        if (cpl_valid && cpl_tag == t) ms[t] = 0;
        else if (n - 1 - marm[t] >= longint'(timeout_limit)) ms[t] = 2;
      end
    end
    if (req_valid && !md) begin
      ms[req_tag] = 1;
      marm[req_tag] = n;
    end
    mo = 0;
    foreach (ms[t]) if (ms[t] != 0) mo++;
    tot = longint'(me) + longint'(mv) + longint'(md) + longint'(mu);
    me = (tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(tot);
  endtask

  task automatic check_all();
    chk("timeout_valid", 32'(timeout_valid), 32'(mv));
    if (mv) chk("timeout_tag", 32'(timeout_tag), 32'(mt));
    chk("err_req_dup", 32'(err_req_dup), 32'(md));
    chk("err_cpl_unexp", 32'(err_cpl_unexp), 32'(mu));
    chk("outstanding", 32'(outstanding), 32'(mo));
    chk("err_count", err_count, me);
    chk("idle", 32'(idle), 32'(mo == 0));
  endtask

  task automatic cyc(input logic rq, input logic [3:0] rt, input logic cv, input logic [3:0] ct);
    req_valid = rq; req_tag = rt; cpl_valid = cv; cpl_tag = ct;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rst_cycle();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; timeout_limit = 99;
    req_valid = 0; req_tag = 0; cpl_valid = 0; cpl_tag = 0;
    foreach (marm[t]) marm[t] = 0;
    @(negedge clk);
    rst_cycle();
    chk("reset_idle", 32'(idle), 1);
    chk("reset_err", err_count, 0);
    chk("reset_out", 32'(outstanding), 0);
    // single timeout: limit 99, report after the 101st edge following the request
    cyc(1, 3, 0, 0);
    repeat (100) cyc(0, 0, 0, 0);
    chk("t1_early", 32'(timeout_valid), 0);
    cyc(0, 0, 0, 0);
    chk("t1_valid", 32'(timeout_valid), 1);
    chk("t1_tag", 32'(timeout_tag), 3);
    chk("t1_err", err_count, 1);
    chk("t1_idle", 32'(idle), 1);
    // completion in time
    rst_cycle();
    cyc(1, 5, 0, 0);
    repeat (49) cyc(0, 0, 0, 0);
    chk("t2_out_before", 32'(outstanding), 1);
    cyc(0, 0, 1, 5);
    chk("t2_out_after", 32'(outstanding), 0);
    repeat (60) cyc(0, 0, 0, 0);
    chk("t2_err", err_count, 0);
    // contended expiries reported in ascending tag order
    rst_cycle();
    cyc(1, 7, 0, 0); cyc(1, 2, 0, 0); cyc(1, 9, 0, 0);
    timeout_limit = 0;
    cyc(0, 0, 0, 0);
    chk("t3_pending", 32'(outstanding), 3);
    cyc(0, 0, 0, 0); chk("t3_first", 32'(timeout_tag), 2);
    cyc(0, 0, 0, 0); chk("t3_second", 32'(timeout_tag), 7);
    cyc(0, 0, 0, 0); chk("t3_third", 32'(timeout_tag), 9);
    chk("t3_out", 32'(outstanding), 0);
    cyc(0, 0, 0, 0); chk("t3_done", 32'(timeout_valid), 0);
    // duplicate request and unexpected completion
    rst_cycle();
    timeout_limit = 99;
    cyc(1, 4, 0, 0); cyc(1, 4, 0, 0);
    chk("t4_dup", 32'(err_req_dup), 1);
    cyc(0, 0, 1, 6);
    chk("t4_dup_pulse", 32'(err_req_dup), 0);
    chk("t4_unexp", 32'(err_cpl_unexp), 1);
    cyc(0, 0, 0, 0);
    chk("t4_unexp_pulse", 32'(err_cpl_unexp), 0);
    chk("t4_err", err_count, 2);
    // re-arm via same-cycle cpl+req at timer 40
    rst_cycle();
    cyc(1, 1, 0, 0);
    repeat (40) cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 1);
    chk("t5_no_dup", 32'(err_req_dup), 0);
    chk("t5_no_unexp", 32'(err_cpl_unexp), 0);
    repeat (100) cyc(0, 0, 0, 0);
    chk("t5_early", 32'(timeout_valid), 0);
    cyc(0, 0, 0, 0);
    chk("t5_valid", 32'(timeout_valid), 1);
    chk("t5_tag", 32'(timeout_tag), 1);
    // saturation: report + dup + unexp on one edge from FFFF_FFFE
    rst_cycle();
    timeout_limit = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    force dut.r_err_count = 32'hFFFF_FFFE;
    #1 release dut.r_err_count;
    me = 32'hFFFF_FFFE;
    cyc(1, 0, 1, 0);
    chk("t6_sat", err_count, 32'hFFFF_FFFF);
    chk("t6_all3", 32'({timeout_valid, err_req_dup, err_cpl_unexp}), 7);
    cyc(1, 3, 1, 3);
    chk("t6_hold", err_count, 32'hFFFF_FFFF);
    // reset mid-flight drops in-flight tags
    timeout_limit = 20;
    cyc(1, 5, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    rst_cycle();
    chk("t7_err", err_count, 0);
    chk("t7_out", 32'(outstanding), 0);
    chk("t7_idle", 32'(idle), 1);
    repeat (30) cyc(0, 0, 0, 0);
    chk("t7_no_late", 32'(timeout_valid), 0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) timeout_limit = $urandom_range(0, 24);
      if ($urandom_range(0, 399) == 0) rst_cycle();
      else cyc($urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)),
               $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cpl_timeout_monitor.md
# cpl_timeout_monitor

Per-tag completion timeout monitor for the simple root-port BFM. Tracks up to NUM_TAGS outstanding non-posted request tags, runs one timer per tag against a cycle limit, and reports each expired tag once. Sits downstream of the delay-to-cycle-count conversion: timeout_limit is the max-count value produced there (expiry after limit+1 cycles). Its error outputs feed the bench's saturating error tally.

## Interface
- NUM_TAGS, 16, number of tracked tags (power of two)
- TAG_W, 4, tag width, log2(NUM_TAGS)
- CNT_W, 32, timer and limit width
- clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- timeout_limit  in  CNT_W  max count; tag expires limit+1 cycles after request
- req_valid  in  1  request issued this cycle
- req_tag  in  TAG_W  tag of request
- cpl_valid  in  1  completion received this cycle
- cpl_tag  in  TAG_W  tag of completion
- timeout_valid  out  1  one-cycle pulse, one expired tag reported
- timeout_tag  out  TAG_W  tag reported with timeout_valid
- err_req_dup  out  1  pulse: request to a non-IDLE tag
- err_cpl_unexp  out  1  pulse: completion to a non-ACTIVE tag
- outstanding  out  TAG_W+1  count of ACTIVE plus EXPIRED tags
- err_count  out  32  saturating total of timeouts, dup requests, unexpected completions
- idle  out  1  high when outstanding == 0

## Operation
- Per-tag state: IDLE, ACTIVE, EXPIRED. Timer held at 0 unless ACTIVE.
- IDLE -> ACTIVE on req for that tag; timer cleared to 0.
- ACTIVE: timer increments each cycle; cpl -> IDLE; timer == timeout_limit -> EXPIRED.
- EXPIRED -> IDLE when selected for report (lowest-numbered EXPIRED tag wins each cycle).
- Same-cycle ordering per tag: cpl evaluated against pre-edge state, req against post-cpl state:
  - IDLE + cpl + req: err_cpl_unexp, tag -> ACTIVE.
  - ACTIVE + cpl + req: no error, tag re-armed, timer 0.
  - EXPIRED + cpl + req: err_cpl_unexp and err_req_dup; tag stays EXPIRED, still reported.
- Request to ACTIVE/EXPIRED tag: err_req_dup, ignored. Completion to IDLE/EXPIRED tag: err_cpl_unexp, ignored.
- A tag reaching the limit on the same edge a cpl arrives: cpl wins, no timeout.
- timeout_limit compared live; lowering it below a running timer expires that tag on next compare (use >=).
- err_count adds 0-3 per cycle (timeout report, dup, unexp), saturates at 32'hFFFF_FFFF, never wraps.

## Timing
- All outputs registered. Reset values: timeout_valid 0, timeout_tag 0, err_req_dup 0, err_cpl_unexp 0, outstanding 0, err_count 0, idle 1; all tags IDLE, timers 0.
- Request sampled at edge E0: timer = k after edge Ek; tag enters EXPIRED at edge E(limit+1); timeout_valid high in the cycle after E(limit+2) is earliest report, i.e. report latency limit+2 edges from request sample, constant when uncontended.
- timeout_limit = 0: EXPIRED at E1, reported at E2.
- Error pulses: asserted the cycle after the offending input edge, one cycle wide.
- Contended expiries: one report per cycle, ascending tag order; pending EXPIRED tags hold, count in outstanding.
- rst_n low mid-operation: all state cleared on that edge; no timeout reported for in-flight tags.

## Structure
- Package cpl_timeout_pkg: tag state enum (IDLE/ACTIVE/EXPIRED), default NUM_TAGS/CNT_W constants, saturating-add helper function.
- Sub-module cpl_tag_timer: one per tag, holds state and timer, inputs arm/clear/ack/limit, outputs state. Top holds priority encoder, counters, error logic.

## Test plan
- timeout_limit 99 (1000 ns at 100 MHz), req tag 3 at E0, no cpl -> timeout_valid with tag 3 after E101, err_count 1, idle 1 after.
- Same limit, req tag 5, cpl tag 5 at E50 -> no timeout, outstanding 1 -> 0, err_count 0.
- Reqs tags 7, 2, 9 same cycle... (serialised over three cycles, E0-E2) then limit 0 applied -> reports in order 2, 7, 9 on consecutive cycles.
- Req tag 4 twice; cpl tag 6 never requested -> err_req_dup and err_cpl_unexp one pulse each, err_count 2.
- cpl and req tag 1 same cycle while ACTIVE at timer 40 -> no error, timer restarts, timeout at limit+2 edges later.
- Force err_count to 32'hFFFF_FFFE, trigger 3 errors in one cycle -> err_count 32'hFFFF_FFFF; assert rst_n low mid-flight -> all outputs at reset values, no late timeout.
